// File: rtl/ram_96x256_ctrl_if.sv
// rtl/ram_96x256_ctrl_if.sv - client, sweep-control and RAM-side signal bundle for ram_96x256_ctrl
//
// Groups every non-clock/reset signal of the coefficient RAM controller.
//   slave  : the controller (consumes requests and ram_dout, drives grants, read data and RAM lines)
//   master : the environment (clients, sweep initiator and the RAM macro itself)
//
// Client N (N = 0, 1):
//   cN_req / cN_wr / cN_addr / cN_wdata : access request, direction, word address, write data
//   cN_gnt    : combinational grant, access commits at the edge where cN_req & cN_gnt
//   cN_rvalid : one-cycle pulse the cycle after a granted read
// Shared:
//   rdata     : registered read data, qualified by c0_rvalid / c1_rvalid
//   clr_start : single-cycle pulse that launches the 256-word zero-fill sweep
//   busy      : high in every sweep cycle
//   clr_done  : single-cycle pulse in the first idle cycle after the sweep
// RAM side:
//   ram_wen, ram_waddr, ram_raddr, ram_din : controller-owned RAM control, address and data
//   ram_dout  : combinational RAM read data at ram_raddr
interface ram_96x256_ctrl_if;
    logic        c0_req;
    logic        c0_wr;
    logic [7:0]  c0_addr;
    logic [95:0] c0_wdata;
    logic        c0_gnt;
    logic        c0_rvalid;

    logic        c1_req;
    logic        c1_wr;
    logic [7:0]  c1_addr;
    logic [95:0] c1_wdata;
    logic        c1_gnt;
    logic        c1_rvalid;

    logic [95:0] rdata;
    logic        clr_start;
    logic        busy;
    logic        clr_done;

    logic        ram_wen;
    logic [7:0]  ram_waddr;
    logic [7:0]  ram_raddr;
    logic [95:0] ram_din;
    logic [95:0] ram_dout;

    modport slave (
        input  c0_req, c0_wr, c0_addr, c0_wdata,
        input  c1_req, c1_wr, c1_addr, c1_wdata,
        input  clr_start,
        input  ram_dout,
        output c0_gnt, c0_rvalid,
        output c1_gnt, c1_rvalid,
        output rdata, busy, clr_done,
        output ram_wen, ram_waddr, ram_raddr, ram_din
    );

    modport master (
        output c0_req, c0_wr, c0_addr, c0_wdata,
        output c1_req, c1_wr, c1_addr, c1_wdata,
        output clr_start,
        output ram_dout,
        input  c0_gnt, c0_rvalid,
        input  c1_gnt, c1_rvalid,
        input  rdata, busy, clr_done,
        input  ram_wen, ram_waddr, ram_raddr, ram_din
    );
endinterface

// File: rtl/ram_96x256_ctrl.sv
// rtl/ram_96x256_ctrl.sv - two-client arbiter and zero-fill sequencer for the 96x256 coefficient RAM
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-low reset (0 = reset)
//   bus : ram_96x256_ctrl_if.slave - client requests/grants, read data, sweep control, RAM lines
//
// Behaviour:
//   IDLE  - at most one client is granted per cycle and drives the RAM combinationally.
//           A granted read captures ram_dout into rdata and pulses that client's rvalid
//           on the following cycle. clr_start moves to CLEAR on the next cycle.
//   CLEAR - writes zero to address cnt for cnt = 0..255 (256 cycles), no grants, busy high.
//           clr_done pulses in the first IDLE cycle afterwards. clr_start is ignored here.
//
// Build option:
//   RAM_CTRL_FIXED_PRIO_EN defined   : client 0 always wins contention, no priority pointer.
//   RAM_CTRL_FIXED_PRIO_EN undefined : 1-bit round-robin pointer, reset to client 0.
module ram_96x256_ctrl (
    input  logic              clk,
    input  logic              rst,
    ram_96x256_ctrl_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic        r_clr_done;
    logic [95:0] r_rdata;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_wen;
    logic [7:0]  w_waddr;
    logic [7:0]  w_raddr;
    logic [95:0] w_din;
    logic        w_rd0;
    logic        w_rd1;
    logic        w_last;

    // Client that wins when both request: 0 -> client 0, 1 -> client 1.
    logic        w_prio;

`ifdef RAM_CTRL_FIXED_PRIO_EN
    assign w_prio = 1'b0;
`else
    logic r_prio;
    assign w_prio = r_prio;

    // After any grant the pointer moves to the client that was not granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (w_gnt0) begin
            r_prio <= 1'b1;
        end else if (w_gnt1) begin
            r_prio <= 1'b0;
        end
    end
`endif

    assign w_last = (r_cnt == 8'hFF);

    // Next state, grants and RAM drive.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_wen       = 1'b0;
        w_waddr     = 8'h00;
        w_raddr     = 8'h00;
        w_din       = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.c0_req && bus.c1_req) begin
                    w_gnt0 = ~w_prio;
                    w_gnt1 = w_prio;
                end else begin
                    w_gnt0 = bus.c0_req;
                    w_gnt1 = bus.c1_req;
                end
                if (w_gnt0) begin
                    w_wen   = bus.c0_wr;
                    w_waddr = bus.c0_addr;
                    w_raddr = bus.c0_addr;
                    w_din   = bus.c0_wdata;
                end else if (w_gnt1) begin
                    w_wen   = bus.c1_wr;
                    w_waddr = bus.c1_addr;
                    w_raddr = bus.c1_addr;
                    w_din   = bus.c1_wdata;
                end
                // A request in the same cycle is still served; the sweep starts next cycle.
                if (bus.clr_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_wen   = 1'b1;
                w_waddr = r_cnt;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grants only ever assert in IDLE, so these are the read commits.
    assign w_rd0 = w_gnt0 & ~bus.c0_wr;
    assign w_rd1 = w_gnt1 & ~bus.c1_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'h00;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rvalid0  <= w_rd0;
            r_rvalid1  <= w_rd1;
            r_clr_done <= (r_state == ST_CLEAR) && w_last;
            if (w_rd0 || w_rd1) begin
                r_rdata <= bus.ram_dout;
            end
            // cnt wraps 255 -> 0 on the last sweep write, leaving it ready for the next sweep.
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 8'd1;
            end else if (bus.clr_start) begin
                r_cnt <= 8'h00;
            end
        end
    end

    assign bus.c0_gnt    = w_gnt0;
    assign bus.c1_gnt    = w_gnt1;
    assign bus.c0_rvalid = r_rvalid0;
    assign bus.c1_rvalid = r_rvalid1;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state == ST_CLEAR);
    assign bus.clr_done  = r_clr_done;
    assign bus.ram_wen   = w_wen;
    assign bus.ram_waddr = w_waddr;
    assign bus.ram_raddr = w_raddr;
    assign bus.ram_din   = w_din;

endmodule

// File: tb/tb_ram_96x256_ctrl.sv
// tb/tb_ram_96x256_ctrl.sv - scoreboard testbench for ram_96x256_ctrl
module tb_ram_96x256_ctrl;

    logic clk;
    logic rst;

    ram_96x256_ctrl_if bus ();

    ram_96x256_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM macro: synchronous write, combinational read.
    logic [95:0] ram_mem [256];
    always_ff @(posedge clk) begin
        if (bus.ram_wen) ram_mem[bus.ram_waddr] <= bus.ram_din;
    end
    assign bus.ram_dout = ram_mem[bus.ram_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [95:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [95:0] m_mem [256];
    logic        m_prio;
    logic        m_clear;
    logic [7:0]  m_cnt;
    logic        m_done;
    int          n_checks;
    int          n_errors;
    int          done_seen;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [95:0] d0,
                        input logic r1, input logic w1, input logic [7:0] a1, input logic [95:0] d1,
                        input logic cs);
        exp_t e;
        logic eg0, eg1;
        @(negedge clk);
        bus.c0_req = r0; bus.c0_wr = w0; bus.c0_addr = a0; bus.c0_wdata = d0;
        bus.c1_req = r1; bus.c1_wr = w1; bus.c1_addr = a1; bus.c1_wdata = d1;
        bus.clr_start = cs;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("c0_rvalid", {95'd0, bus.c0_rvalid}, {95'd0, e.v0});
            chk("c1_rvalid", {95'd0, bus.c1_rvalid}, {95'd0, e.v1});
            chk("rdata", bus.rdata, e.d);
        end else begin
            chk("c0_rvalid_idle", {95'd0, bus.c0_rvalid}, 96'd0);
            chk("c1_rvalid_idle", {95'd0, bus.c1_rvalid}, 96'd0);
        end
        if (bus.clr_done) done_seen++;
        chk("clr_done", {95'd0, bus.clr_done}, {95'd0, m_done});
        m_done = 1'b0;
        chk("busy", {95'd0, bus.busy}, {95'd0, m_clear});

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!m_clear) begin
            if (r0 && r1) begin
`ifdef RAM_CTRL_FIXED_PRIO_EN
                eg0 = 1'b1;
`else
                eg0 = ~m_prio;
                eg1 = m_prio;
`endif
            end else begin
                eg0 = r0;
                eg1 = r1;
            end
        end
        chk("c0_gnt", {95'd0, bus.c0_gnt}, {95'd0, eg0});
        chk("c1_gnt", {95'd0, bus.c1_gnt}, {95'd0, eg1});

        if (m_clear) begin
            chk("clr_wen", {95'd0, bus.ram_wen}, 96'd1);
            chk("clr_waddr", {88'd0, bus.ram_waddr}, {88'd0, m_cnt});
            chk("clr_din", bus.ram_din, 96'd0);
            m_mem[m_cnt] = '0;
            if (m_cnt == 8'hFF) begin
                m_clear = 1'b0;
                m_done  = 1'b1;
            end
            m_cnt = m_cnt + 8'd1;
        end else begin
            if (eg0) begin
                if (w0) m_mem[a0] = d0;
                else exp_q.push_back('{v0: 1'b1, v1: 1'b0, d: m_mem[a0]});
                m_prio = 1'b1;
            end else if (eg1) begin
                if (w1) m_mem[a1] = d1;
                else exp_q.push_back('{v0: 1'b0, v1: 1'b1, d: m_mem[a1]});
                m_prio = 1'b0;
            end else begin
                chk("idle_wen", {95'd0, bus.ram_wen}, 96'd0);
                chk("idle_din", bus.ram_din, 96'd0);
            end
            if (cs) begin
                m_clear = 1'b1;
                m_cnt   = 8'h00;
            end
        end
    endtask

    // Asynchronous reset asserted at a falling edge with a read request held on client 0.
    task automatic do_reset();
        @(negedge clk);
        bus.c0_req = 1'b1; bus.c0_wr = 1'b0; bus.c0_addr = 8'h00; bus.c0_wdata = '0;
        bus.c1_req = 1'b0; bus.c1_wr = 1'b0; bus.c1_addr = 8'h00; bus.c1_wdata = '0;
        bus.clr_start = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_c0_rvalid", {95'd0, bus.c0_rvalid}, 96'd0);
        chk("rst_c1_rvalid", {95'd0, bus.c1_rvalid}, 96'd0);
        chk("rst_rdata", bus.rdata, 96'd0);
        chk("rst_busy", {95'd0, bus.busy}, 96'd0);
        chk("rst_clr_done", {95'd0, bus.clr_done}, 96'd0);
        exp_q.delete();
        m_prio  = 1'b0;
        m_clear = 1'b0;
        m_cnt   = 8'h00;
        m_done  = 1'b0;
        @(negedge clk);
        bus.c0_req = 1'b0;
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
    endtask

    task automatic wr(input int c, input logic [7:0] a, input logic [95:0] d);
        if (c == 0) step(1, 1, a, d, 0, 0, 8'h00, '0, 0);
        else        step(0, 0, 8'h00, '0, 1, 1, a, d, 0);
    endtask

    task automatic rd(input int c, input logic [7:0] a);
        if (c == 0) step(1, 0, a, '0, 0, 0, 8'h00, '0, 0);
        else        step(0, 0, 8'h00, '0, 1, 0, a, '0, 0);
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()} | 96'd1;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_seen = 0;
        m_prio = 1'b0; m_clear = 1'b0; m_cnt = 8'h00; m_done = 1'b0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = '0;
            ram_mem[i] = '0;
        end
        rst = 1'b0;
        bus.c0_req = 0; bus.c0_wr = 0; bus.c0_addr = 0; bus.c0_wdata = '0;
        bus.c1_req = 0; bus.c1_wr = 0; bus.c1_addr = 0; bus.c1_wdata = '0;
        bus.clr_start = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("por_rdata", bus.rdata, 96'd0);
        chk("por_busy", {95'd0, bus.busy}, 96'd0);
        @(negedge clk);
        rst = 1'b1;

        // Traffic, then reset in the middle of it.
        for (int i = 0; i < 6; i++) begin
            wr(i % 2, 8'(i + 1), rnd96());
            rd((i + 1) % 2, 8'(i + 1));
        end
        do_reset();

        // Write then read back through the other client.
        wr(0, 8'h10, {12{8'hA5}});
        rd(1, 8'h10);
        idle(1);

        // Both clients contending for six cycles.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 8'h10, '0, 1, 0, 8'(i + 1), '0, 0);
        idle(1);

        // Lone client 1 streaming reads of 0xFF.
        wr(0, 8'hFF, rnd96());
        for (int i = 0; i < 8; i++) rd(1, 8'hFF);
        idle(1);

        // Fill every word, then sweep with a request in the start cycle and a stray clr_start.
        for (int i = 0; i < 256; i++) wr(i % 2, 8'(i), rnd96());
        done_seen = 0;
        step(1, 0, 8'h33, '0, 0, 0, 8'h00, '0, 1);
        for (int i = 1; i <= 256; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), rnd96(),
                 $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), rnd96(),
                 (i == 100));
        end
        idle(3);
        chk("clr_done_count", 96'(done_seen), 96'd1);
        rd(0, 8'h00);
        rd(1, 8'h80);
        rd(0, 8'hFF);
        idle(1);

        // Reset after 50 sweep cycles.
        for (int i = 0; i < 64; i++) wr(i % 2, 8'(i), rnd96());
        done_seen = 0;
        step(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 1);
        for (int i = 0; i < 50; i++) step(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        do_reset();
        idle(300);
        chk("abort_clr_done_count", 96'(done_seen), 96'd0);
        for (int i = 0; i <= 50; i++) rd(i % 2, 8'(i));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_96x256_ctrl.md
# ram_96x256_ctrl

Arbiter and sequencer in front of the 96x256 coefficient RAM. Two clients share the RAM: client 0 (NTT/butterfly datapath) and client 1 (load/store/pack unit). The block grants at most one access per cycle, returns read data registered one cycle later, and runs a 256-cycle zero-fill sweep on command. Sits between the clients and the RAM; the controller owns every RAM control and address line.

## Interface
- No parameters; geometry fixed at 256 words x 96 bits, 8-bit address.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cN_req  in  1  client N (N=0,1) access request; held until granted
- cN_wr  in  1  1 = write, 0 = read; valid with cN_req
- cN_addr  in  8  word address
- cN_wdata  in  96  write data
- cN_gnt  out  1  combinational grant; access commits at the edge where cN_req & cN_gnt
- cN_rvalid  out  1  registered; high one cycle, the cycle after a granted read
- rdata  out  96  registered read data, shared by both clients; qualified by cN_rvalid
- clr_start  in  1  single-cycle pulse; start zero-fill sweep
- busy  out  1  high while in CLEAR
- clr_done  out  1  registered single-cycle pulse after the last zero-fill write
- ram_wen  out  1  RAM write enable
- ram_waddr, ram_raddr  out  8  RAM write/read address
- ram_din  out  96  RAM write data
- ram_dout  in  96  RAM combinational read data

## Operation
- FSM states: IDLE, CLEAR. Reset -> IDLE.
- IDLE: arbitration picks at most one client per cycle; the winner drives the RAM combinationally. ram_wen = winner's cN_wr; ram_waddr = ram_raddr = winner's addr; ram_din = winner's wdata.
- No request: ram_wen=0, addresses 0, ram_din 0.
- Read commit: ram_dout captured into rdata; cN_rvalid=1 next cycle. rdata holds its value until the next read commit.
- Write commit: the RAM updates at the same edge. A read of that address in a later cycle returns the new data.
- Round-robin: 1-bit priority pointer, reset value 0 (client 0 favoured). With both requesting, the pointer holder wins. After any grant the pointer points to the non-granted client. A lone requester is always granted.
- clr_start in IDLE -> CLEAR next cycle; 8-bit counter cnt cleared to 0.
- CLEAR: ram_wen=1, ram_waddr=cnt, ram_din=0, cnt increments each cycle. Both gnt=0. At cnt=255 the write completes, then -> IDLE, clr_done pulses in the first IDLE cycle.
- The sweep takes exactly 256 cycles.
- clr_start in CLEAR is ignored; no restart.
- clr_start in the same cycle as a client request: the request is granted that cycle, and CLEAR starts next cycle.
- Reset mid-CLEAR aborts the sweep: immediate IDLE, cnt=0, no clr_done. RAM contents are left partially cleared; the RAM's own reset is not driven by this block.

## Timing
- Reset values: cN_rvalid=0, rdata=0, busy=0, clr_done=0, priority pointer=0, cnt=0, state IDLE.
- Grants, ram_* outputs and busy are combinational from state and inputs.
- Read latency: 1 cycle from the commit edge to rvalid/rdata. Throughput: 1 access per cycle total.
- busy=1 in every CLEAR cycle (256 cycles). clr_done is high in the cycle immediately after the last CLEAR cycle.

## Configuration
- RAM_CTRL_FIXED_PRIO_EN defined: fixed priority. Client 0 always wins contention; the priority pointer is not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset with rst=0 mid-traffic: all registered outputs 0, gnt follows requests next cycle. Then c0 writes 0xA5..A5 at addr 0x10; c1 reads 0x10 next cycle -> c1_rvalid pulses with rdata=0xA5..A5.
- Both clients request every cycle for 6 cycles (round-robin build): grants alternate 0,1,0,1,0,1. With the FIXED_PRIO macro defined: c0 granted all 6 cycles.
- c1 alone reads addr 0xFF repeatedly: granted every cycle; rvalid high continuously, one per read, in order.
- clr_start after filling all 256 addresses with nonzero data: busy for 256 cycles, gnt=0 throughout, clr_done pulses once. Reads of addr 0, 0x80 and 0xFF then return 0.
- clr_start pulsed again at cycle 100 of a sweep: ignored; sweep still ends at cycle 256 with exactly one clr_done.
- rst asserted at sweep cycle 50: busy drops immediately and no clr_done. Addr 0..49 read 0; addr 50 keeps its old value.
